// File: rtl/chunk_uart_tx_pkg.sv
// ============================================================================
// Module  : chunk_uart_tx_pkg
// Brief   : Shared state encoding, frame constants and byte-select helper
//           for the chunk UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package chunk_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam int FRAME_BYTES          = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Byte 0 is the chunk type, bytes 1/2 are the payload low/high halves.
    function automatic logic [7:0] frame_byte(input logic [23:0] frame,
                                              input logic [1:0]  idx);
        logic [7:0] w_byte;
        case (idx)
            2'd0:    w_byte = frame[7:0];
            2'd1:    w_byte = frame[15:8];
            2'd2:    w_byte = frame[23:16];
            default: w_byte = 8'h00;
        endcase
        return w_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_uart_tx_if.sv
// ============================================================================
// Module  : chunk_uart_tx_if
// Brief   : Chunk producer to UART transmitter request/acknowledge bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface chunk_uart_tx_if;

    logic        should_update;
    logic [7:0]  tx_chunk_type;
    logic [15:0] tx_chunk_bytes;
    logic        ack;
    logic        busy;

    modport master (
        output should_update,
        output tx_chunk_type,
        output tx_chunk_bytes,
        input  ack,
        input  busy
    );

    modport slave (
        input  should_update,
        input  tx_chunk_type,
        input  tx_chunk_bytes,
        output ack,
        output busy
    );

endinterface

`default_nettype wire

// File: rtl/chunk_uart_tx_byte.sv
// ============================================================================
// Module  : uart_tx_byte
// Brief   : 8N1 serialiser for a single byte; done marks the last stop-bit
//           cycle so a new start can be accepted without a gap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
    import chunk_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 8
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    input  wire logic       start,
    input  wire logic [7:0] data,
    output logic            tx,
    output logic            done
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic w_bit_end;
    logic w_can_load;

    assign w_bit_end  = (r_cnt == c_CNT_LAST);
    assign w_can_load = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign done       = (r_state == STOP) && w_bit_end;
    assign tx         = r_tx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
        end else if (start && w_can_load) begin
            r_state   <= START;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= data;
            r_tx      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_state   <= DATA;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            // Shift register keeps the next bit at index 1.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/chunk_uart_tx.sv
// ============================================================================
// Module  : chunk_uart_tx
// Brief   : Sends one {type, payload} chunk as a gapless 3-byte 8N1 frame and
//           pulses ack once the final stop bit has completed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_uart_tx
    import chunk_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 8
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    chunk_uart_tx_if.slave  bus,
    output logic            uart_tx
);

    localparam logic [1:0] c_LAST_BYTE = 2'(FRAME_BYTES - 1);

    state_t      r_state;
    logic [23:0] r_frame;
    logic [1:0]  r_byte_idx;
    logic        r_ack;
    logic        r_busy;

    logic        w_byte_done;
    logic        w_last_byte;
    logic        w_byte_start;
    logic [7:0]  w_byte_data;

    assign w_last_byte = (r_byte_idx == c_LAST_BYTE);

    // Byte starts are combinational so that the start bit follows the accept
    // edge by one cycle and successive bytes abut with no idle gap.
    assign w_byte_start = ((r_state == IDLE) && bus.should_update) ||
                          ((r_state == DATA) && w_byte_done && !w_last_byte);
    assign w_byte_data  = (r_state == IDLE) ? bus.tx_chunk_type
                                            : frame_byte(r_frame, r_byte_idx + 2'd1);

    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_byte (
        .CLK   (CLK),
        .RST   (RST),
        .start (w_byte_start),
        .data  (w_byte_data),
        .tx    (uart_tx),
        .done  (w_byte_done)
    );

    // DATA covers the whole three-byte serialisation; bit-level phases live
    // in the byte serialiser.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_frame    <= 24'h000000;
            r_byte_idx <= 2'd0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (bus.should_update) begin
                        r_frame    <= {bus.tx_chunk_bytes, bus.tx_chunk_type};
                        r_byte_idx <= 2'd0;
                        r_busy     <= 1'b1;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_byte_done) begin
                        if (w_last_byte) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chunk_uart_tx.sv
// ============================================================================
// Module  : tb_chunk_uart_tx
// Brief   : Directed, table-driven bench for chunk_uart_tx at 4 clocks/bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chunk_uart_tx;

    localparam int c_CPB = 4;

    logic CLK;
    logic RST;
    logic uart_tx;

    chunk_uart_tx_if bus ();

    chunk_uart_tx #(
        .CLKS_PER_BIT (c_CPB),
        .CNT_WIDTH    (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .uart_tx (uart_tx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  ty;
        logic [15:0] by;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs [5];
    int   n_tests;
    int   n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; the following posedge is the
    // accept edge. Returns at the negedge of the first cycle after ack.
    task automatic run_frame(input string nm, input logic [7:0] ty, input logic [15:0] by,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input bit change_mid, input bit hold);
        logic [29:0] exp_ser;
        logic [29:0] got;
        logic        ack_at_end;
        int          ser_err;
        int          ack_err;
        int          busy_err;
        exp_ser  = {1'b1, e2, 1'b0, 1'b1, e1, 1'b0, 1'b1, e0, 1'b0};
        got      = '0;
        ser_err  = 0;
        ack_err  = 0;
        busy_err = 0;
        ack_at_end = 1'b0;
        bus.should_update  = 1'b1;
        bus.tx_chunk_type  = ty;
        bus.tx_chunk_bytes = by;
        @(posedge CLK);
        for (int c = 1; c <= 30 * c_CPB + 1; c++) begin
            @(negedge CLK);
            if (change_mid && c == 40) begin
                bus.tx_chunk_bytes = 16'hFFFF;
                bus.tx_chunk_type  = 8'hFF;
            end
            if (c <= 30 * c_CPB) begin
                if (uart_tx !== exp_ser[(c - 1) / c_CPB]) ser_err++;
                if ((c - 1) % c_CPB == 2) got[(c - 1) / c_CPB] = uart_tx;
                if (bus.ack !== 1'b0) ack_err++;
            end else begin
                ack_at_end = bus.ack;
            end
            if (bus.busy !== 1'b1) busy_err++;
        end
        if (!hold) bus.should_update = 1'b0;
        check({nm, " serial bit errors"}, ser_err, 0);
        check({nm, " framing"}, {26'd0, got[0], got[9], got[10], got[19], got[20], got[29]}, 6'b010101);
        check({nm, " byte0"}, got[8:1], e0);
        check({nm, " byte1"}, got[18:11], e1);
        check({nm, " byte2"}, got[28:21], e2);
        check({nm, " early ack"}, ack_err, 0);
        check({nm, " ack at +121"}, ack_at_end, 1'b1);
        check({nm, " busy gaps"}, busy_err, 0);
        @(negedge CLK);
        check({nm, " post ack"}, {29'd0, bus.ack, bus.busy, uart_tx}, 3'b001);
    endtask

    initial begin
        int errs;
        logic [7:0] disp_vals [4];
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{ty: 8'h06, by: 16'hA53C, e0: 8'h06, e1: 8'h3C, e2: 8'hA5};
        vecs[1] = '{ty: 8'h00, by: 16'h0000, e0: 8'h00, e1: 8'h00, e2: 8'h00};
        vecs[2] = '{ty: 8'hFF, by: 16'hFFFF, e0: 8'hFF, e1: 8'hFF, e2: 8'hFF};
        vecs[3] = '{ty: 8'h81, by: 16'h0102, e0: 8'h81, e1: 8'h02, e2: 8'h01};
        vecs[4] = '{ty: 8'h55, by: 16'hAA55, e0: 8'h55, e1: 8'h55, e2: 8'hAA};
        disp_vals[0] = 8'h11;
        disp_vals[1] = 8'h22;
        disp_vals[2] = 8'h33;
        disp_vals[3] = 8'h44;

        RST = 1'b1;
        bus.should_update  = 1'b0;
        bus.tx_chunk_type  = 8'h00;
        bus.tx_chunk_bytes = 16'h0000;
        #1;
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset ack", bus.ack, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].ty, vecs[i].by,
                      vecs[i].e0, vecs[i].e1, vecs[i].e2, 1'b0, 1'b0);
            repeat (2) @(negedge CLK);
        end

        // Payload altered mid-frame must not reach the line.
        run_frame("stable", 8'h06, 16'hA53C, 8'h06, 8'h3C, 8'hA5, 1'b1, 1'b0);
        @(negedge CLK);

        // Display-stage style producer: drop request after ack, one prepare cycle.
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("disp%0d", i), 8'h06, {disp_vals[i], 8'(i)},
                      8'h06, 8'(i), disp_vals[i], 1'b0, 1'b0);
            @(negedge CLK);
        end
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 1'b0) errs++;
        end
        check("disp no extra frame", errs, 0);

        // Held request: second frame's start bit two cycles after the ack cycle.
        run_frame("held1", 8'h21, 16'h4321, 8'h21, 8'h21, 8'h43, 1'b0, 1'b1);
        run_frame("held2", 8'h7E, 16'hC3E7, 8'h7E, 8'hE7, 8'hC3, 1'b0, 1'b0);
        @(negedge CLK);

        // Reset during byte1 bit3 (cycles 57..60 after accept).
        bus.should_update  = 1'b1;
        bus.tx_chunk_type  = 8'h5A;
        bus.tx_chunk_bytes = 16'h1234;
        @(posedge CLK);
        repeat (57) @(negedge CLK);
        check("pre-reset line low", uart_tx, 1'b0);
        RST = 1'b1;
        #1;
        check("reset mid uart_tx", uart_tx, 1'b1);
        check("reset mid busy", bus.busy, 1'b0);
        errs = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (bus.ack !== 1'b0 || uart_tx !== 1'b1) errs++;
        end
        RST = 1'b0;
        for (int c = 0; c < 0; c++) @(negedge CLK);
        check("reset hold quiet", errs, 0);
        run_frame("after reset", 8'h5A, 16'h1234, 8'h5A, 8'h34, 8'h12, 1'b0, 1'b0);

        // Idle line.
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            if (uart_tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== 1'b0) errs++;
        end
        check("idle line", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
